// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: fetch vs. load/store, data has priority.
// Define ARB_FAIRNESS_EN to bound data grant streaks while fetch waits.
module mem_arbiter #(
  parameter int unsigned MAX_D_STREAK = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic [3:0]  d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        mem_en,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        stall_out
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    IREAD = 2'd1,
    DREAD = 2'd2
  } owner_t;

  owner_t state;
  logic   fetch_turn;

  if (MAX_D_STREAK < 1 || MAX_D_STREAK > 15) begin : g_bad_streak
    $error("mem_arbiter: MAX_D_STREAK must be in 1..15");
  end

`ifdef ARB_FAIRNESS_EN
  localparam logic [3:0] STREAK_LIMIT = 4'(MAX_D_STREAK);

  logic [3:0] streak;

  // Once data has won STREAK_LIMIT times in a row against a waiting fetch,
  // the next cycle belongs to fetch.
  assign fetch_turn = i_req & (streak == STREAK_LIMIT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      streak <= '0;
    end else if (!i_req || i_gnt) begin
      streak <= '0;
    end else if (d_gnt) begin
      streak <= streak + 4'd1;
    end
  end
`else
  assign fetch_turn = 1'b0;
`endif

  always_comb begin
    d_gnt = d_req & ~fetch_turn;
    i_gnt = i_req & ~d_gnt;
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (d_gnt) begin
      mem_en    = 1'b1;
      mem_we    = d_we;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end else if (i_gnt) begin
      mem_en    = 1'b1;
      mem_addr  = i_addr;
    end
  end

  assign stall_out = (i_req & ~i_gnt) | (d_req & ~d_gnt);

  // Owner of the read whose data appears on mem_rdata this cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else if (i_gnt) begin
      state <= IREAD;
    end else if (d_gnt && d_we == 4'b0000) begin
      state <= DREAD;
    end else begin
      state <= IDLE;
    end
  end

  assign i_rvalid = (state == IREAD);
  assign d_rvalid = (state == DREAD);
  assign i_rdata  = i_rvalid ? mem_rdata : '0;
  assign d_rdata  = d_rvalid ? mem_rdata : '0;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter that shares one synchronous memory between the instruction-fetch requester and the load/store path of the execute stage. It grants at most one access per cycle and tracks which requester owns the read in flight, so returned data is steered to the right port. It raises a pipeline stall whenever a pending request is not granted. It sits between the fetch/execute stages and the memory macro.

## Interface
Parameters:
- MAX_D_STREAK, default 4: consecutive data grants allowed while fetch waits (used only with fairness compiled in); legal range 1–15.

Ports:
- clk  in  1  core clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- i_req  in  1  fetch read request.
- i_addr  in  32  fetch address.
- i_gnt  out  1  fetch request accepted this cycle.
- i_rvalid  out  1  i_rdata valid.
- i_rdata  out  32  fetch read data.
- d_req  in  1  data request (read or write).
- d_we  in  4  byte write enables; 0 means read.
- d_addr  in  32  data address.
- d_wdata  in  32  write data.
- d_gnt  out  1  data request accepted this cycle.
- d_rvalid  out  1  d_rdata valid (reads only).
- d_rdata  out  32  load data.
- mem_en  out  1  memory access strobe.
- mem_we  out  4  memory byte write enables.
- mem_addr  out  32  memory address.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data, valid the cycle after a read strobe.
- stall_out  out  1  a request is pending and not granted.

## Operation
- Grant is combinational per cycle; at most one of i_gnt/d_gnt is high.
- Default priority: data over fetch (the oldest instruction gets memory first).
- Granted port drives mem_addr/mem_we/mem_wdata; mem_en = i_gnt | d_gnt. Fetch grant forces mem_we = 0, mem_wdata = 0. With no grant, all mem_* outputs are 0.
- Owner register, states IDLE, IREAD, DREAD:
  - Next state IREAD on i_gnt.
  - Next state DREAD on d_gnt with d_we == 0.
  - Next state IDLE otherwise, including data writes.
- i_rvalid = (state == IREAD); d_rvalid = (state == DREAD). Both rdata outputs pass mem_rdata through, gated to 0 when their rvalid is low.
- Writes complete on the grant cycle; no response is produced.
- stall_out = (i_req & ~i_gnt) | (d_req & ~d_gnt).
- Requests with req low are ignored regardless of address, data or enable values.
- A requester must hold its request and fields stable until granted.

## Timing
- Reset values: state IDLE, streak counter 0. All registered outputs are 0. i_rvalid and d_rvalid are 0 during reset and the first cycle after it.
- Read latency: grant in cycle N, rvalid plus data in cycle N+1. A new grant may issue in cycle N+1 (full throughput, one access per cycle).
- Simultaneous i_req and d_req: data is granted and fetch stalls, subject to fairness.
- Back-to-back data reads: each d_rvalid pulses for exactly one cycle per grant.
- If reset is asserted while a read is in flight, the response is discarded and the state returns to IDLE immediately.

## Configuration
- ARB_FAIRNESS_EN defined:
  - A 4-bit streak counter increments on each d_gnt while i_req is high.
  - When the counter equals MAX_D_STREAK and i_req is high, fetch is granted instead of data.
  - The counter clears on i_gnt or any cycle where i_req is low.
- ARB_FAIRNESS_EN undefined: strict data priority, no counter. Fetch can starve while d_req stays high.

## Test plan
- Fetch only: i_req=1, i_addr=0x100, memory returns 0x00000013 → i_gnt=1 in cycle 0; i_rvalid=1 and i_rdata=0x13 in cycle 1; stall_out=0.
- Simultaneous: i_req=1, d_req=1, d_we=0, d_addr=0x2000 → d_gnt=1, i_gnt=0, stall_out=1 in cycle 0. Next cycle d_rvalid=1; i_gnt=1 when d_req drops.
- Write: d_req=1, d_we=4'b0011, d_addr=0x2004, d_wdata=0xBEEF → mem_en=1, mem_we=0011, mem_wdata=0xBEEF same cycle; no d_rvalid follows.
- Fairness (ARB_FAIRNESS_EN, MAX_D_STREAK=4): i_req and d_req held high → d_gnt for 4 cycles, i_gnt in cycle 5, then the pattern repeats. Without the macro, d_gnt every cycle.
- Reset mid-read: assert reset in the cycle after a data-read grant → d_rvalid=0, state IDLE, all outputs 0 until reset deasserts.
